// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for the single-port DFF RAM
module mem_arbiter #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [DATA_BITS-1:0] a_wdata,
   output logic                 a_ack,
   output logic [DATA_BITS-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [DATA_BITS-1:0] b_wdata,
   output logic                 b_ack,
   output logic [DATA_BITS-1:0] b_rdata,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 mem_lr_n,
   output logic                 mem_ce_n,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   we_q, we_d;
   logic                   prio_q, prio_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [DATA_BITS-1:0]   wdata_q, wdata_d;
   logic                   lr_n_q, lr_n_d;
   logic                   ce_n_q, ce_n_d;
   logic [DATA_BITS-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_BITS-1:0]   b_rdata_q, b_rdata_d;
   logic                   win_b;
   logic                   sel_we;

   // owner/prio encoding: 0 = port A, 1 = port B
   assign win_b  = b_req & (~a_req | prio_q);
   assign sel_we = win_b ? b_we : a_we;

   // next-state: grant and latch in IDLE, one strobe cycle, one response cycle; everything holds while ena is low
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      prio_d    = prio_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      lr_n_d    = lr_n_q;
      ce_n_d    = ce_n_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (a_req | b_req) begin
                  owner_d = win_b;
                  we_d    = sel_we;
                  addr_d  = win_b ? b_addr : a_addr;
                  wdata_d = win_b ? b_wdata : a_wdata;
                  lr_n_d  = ~sel_we;
                  ce_n_d  = sel_we;
                  state_d = sel_we ? WRITE : READ;
               end
            end
            WRITE, READ: begin
               lr_n_d  = 1'b1;
               ce_n_d  = 1'b1;
               state_d = RESP;
            end
            RESP: begin
               a_rdata_d = (!we_q && !owner_q) ? mem_rdata : a_rdata_q;
               b_rdata_d = (!we_q && owner_q) ? mem_rdata : b_rdata_q;
               prio_d    = ~owner_q;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         prio_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lr_n_q    <= 1'b1;
         ce_n_q    <= 1'b1;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         prio_q    <= prio_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lr_n_q    <= lr_n_d;
         ce_n_q    <= ce_n_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   assign a_ack     = ena & (state_q == RESP) & ~owner_q;
   assign b_ack     = ena & (state_q == RESP) & owner_q;
   assign busy      = state_q != IDLE;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_lr_n  = lr_n_q;
   assign mem_ce_n  = ce_n_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized traffic against a transaction-level model
module tb_mem_arbiter;
   logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
   logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [3:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_wdata = '0, b_wdata = '0;
   logic       a_ack, b_ack, mem_lr_n, mem_ce_n, busy;
   logic [7:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_addr;
   logic [7:0] ram [16];

   int errors = 0, checks = 0;

   mem_arbiter #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_lr_n(mem_lr_n), .mem_ce_n(mem_ce_n),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // 16-byte RAM: write on lr_n low, registered read on ce_n low, frozen by ena, cleared by reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ram[i] <= '0;
         mem_rdata <= '0;
      end else if (ena) begin
         if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
         if (!mem_ce_n) mem_rdata <= ram[mem_addr];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   typedef struct {
      logic       ar, aw;
      logic [3:0] aa;
      logic [7:0] ad;
      logic       br, bw;
      logic [3:0] ba;
      logic [7:0] bd;
      logic [63:0] e;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({a_ack, b_ack, busy, mem_lr_n, mem_ce_n, mem_addr, mem_wdata, a_rdata, b_rdata});
   endfunction

   function automatic logic [63:0] pack(input logic aa, ba, bs, lr, ce, input logic [3:0] ad,
                                         input logic [7:0] wd, ar, br);
      return 64'({aa, ba, bs, lr, ce, ad, wd, ar, br});
   endfunction

   function automatic vec_t mk(input logic ar, aw, input logic [3:0] aa, input logic [7:0] ad,
                               input logic br, bw, input logic [3:0] ba, input logic [7:0] bd,
                               input logic [63:0] e);
      vec_t v;
      v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
      v.br = br; v.bw = bw; v.ba = ba; v.bd = bd; v.e = e;
      return v;
   endfunction

   task automatic idle_in();
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
      b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
      ena = 1'($urandom);
      #1 chk("reset_values", outs(), pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      #1 chk("reset_hold", outs(), pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
      idle_in();
      ena = 1;
      rst_n = 1;
   endtask

   task automatic txn(input logic port, we, input logic [3:0] ad, input logic [7:0] wd);
      logic got;
      got = 0;
      @(negedge clk);
      if (port) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
      else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge clk);
         #1 if (port ? b_ack : a_ack) got = 1;
      end
      a_req = 0; b_req = 0;
      chk("txn_ack", 64'(got), 64'(1));
   endtask

   // transaction-level reference model for the random phase
   int         m_cnt;
   logic       m_owner, m_we, m_prio;
   logic [3:0] m_addr;
   logic [7:0] m_wd, m_ard, m_brd;
   logic [7:0] m_mem [16];
   int         a_waits, b_waits;

   task automatic model_step();
      if (!ena) return;
      if (m_cnt == 0) begin
         if (a_req || b_req) begin
            m_owner = b_req && (!a_req || m_prio);
            m_we    = m_owner ? b_we : a_we;
            m_addr  = m_owner ? b_addr : a_addr;
            m_wd    = m_owner ? b_wdata : a_wdata;
            m_cnt   = 2;
         end
      end else if (m_cnt == 2) m_cnt = 1;
      else begin
         if (m_we) m_mem[m_addr] = m_wd;
         else if (m_owner) m_brd = m_mem[m_addr];
         else m_ard = m_mem[m_addr];
         m_prio = !m_owner;
         m_cnt  = 0;
      end
   endtask

   task automatic new_a();
      a_req = 1; a_we = 1'($urandom); a_addr = 4'($urandom_range(0, 3)); a_wdata = 8'($urandom); a_waits = 0;
   endtask

   task automatic new_b();
      b_req = 1; b_we = 1'($urandom); b_addr = 4'($urandom_range(0, 3)); b_wdata = 8'($urandom); b_waits = 0;
   endtask

   initial begin
      int n_ack;
      tv[0]  = mk(1, 1, 5, 'h3C, 0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 0, 'h00, 'h00, 0));
      tv[1]  = mk(1, 1, 5, 'h3C, 0, 0, 0, 0,    pack(0, 0, 1, 0, 1, 5, 'h3C, 'h00, 0));
      tv[2]  = mk(1, 0, 5, 0,    0, 0, 0, 0,    pack(1, 0, 1, 1, 1, 5, 'h3C, 'h00, 0));
      tv[3]  = mk(1, 0, 5, 0,    0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 5, 'h3C, 'h00, 0));
      tv[4]  = mk(1, 0, 5, 0,    0, 0, 0, 0,    pack(0, 0, 1, 1, 0, 5, 'h00, 'h00, 0));
      tv[5]  = mk(1, 0, 5, 0,    0, 0, 0, 0,    pack(1, 0, 1, 1, 1, 5, 'h00, 'h00, 0));
      tv[6]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 5, 'h00, 'h3C, 0));
      tv[7]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 5, 'h00, 'h3C, 0));
      tv[8]  = mk(1, 0, 9, 0,    1, 1, 9, 'hA5, pack(0, 0, 0, 1, 1, 5, 'h00, 'h3C, 0));
      tv[9]  = mk(1, 0, 9, 0,    1, 1, 9, 'hA5, pack(0, 0, 1, 0, 1, 9, 'hA5, 'h3C, 0));
      tv[10] = mk(1, 0, 9, 0,    1, 1, 9, 'hA5, pack(0, 1, 1, 1, 1, 9, 'hA5, 'h3C, 0));
      tv[11] = mk(1, 0, 9, 0,    0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 9, 'hA5, 'h3C, 0));
      tv[12] = mk(1, 0, 9, 0,    0, 0, 0, 0,    pack(0, 0, 1, 1, 0, 9, 'h00, 'h3C, 0));
      tv[13] = mk(1, 0, 9, 0,    0, 0, 0, 0,    pack(1, 0, 1, 1, 1, 9, 'h00, 'h3C, 0));
      tv[14] = mk(0, 0, 0, 0,    0, 0, 0, 0,    pack(0, 0, 0, 1, 1, 9, 'h00, 'hA5, 0));

      // round trip on A, then a same-address collision with B holding priority
      do_reset();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         a_req = tv[i].ar; a_we = tv[i].aw; a_addr = tv[i].aa; a_wdata = tv[i].ad;
         b_req = tv[i].br; b_we = tv[i].bw; b_addr = tv[i].ba; b_wdata = tv[i].bd;
         #1 chk($sformatf("vec%0d", i), outs(), tv[i].e);
      end

      // contention: both read continuously from reset, grants alternate every 3 cycles
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a_req = 1; a_we = 0; a_addr = 1;
            b_req = 1; b_we = 0; b_addr = 2;
         end
         #1 chk($sformatf("contend%0d", i), 64'({a_ack, b_ack}), 64'({i % 6 == 2, i % 6 == 5}));
      end

      // enable stall during READ
      do_reset();
      txn(0, 1, 3, 8'h77);
      @(negedge clk);
      a_req = 1; a_we = 0; a_addr = 3;
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ena = 0;
         #1 chk("stall_ce", 64'({mem_ce_n, a_ack}), 64'(0));
         n_ack += int'(a_ack);
      end
      @(negedge clk);
      ena = 1;
      #1 chk("stall_resume", 64'({mem_ce_n, a_ack}), 64'(0));
      n_ack += int'(a_ack);
      @(negedge clk);
      #1 chk("stall_ack", 64'(a_ack), 64'(1));
      n_ack += int'(a_ack);
      a_req = 0;
      @(negedge clk);
      #1 chk("stall_done", 64'({a_ack, mem_ce_n, a_rdata}), 64'({1'b0, 1'b1, 8'h77}));
      n_ack += int'(a_ack);
      chk("stall_ack_count", 64'(n_ack), 64'(1));

      // reset during WRITE abandons the transaction and clears the RAM
      do_reset();
      txn(0, 1, 7, 8'h55);
      txn(0, 1, 2, 8'h5A);
      txn(0, 0, 2, 8'h00);
      @(negedge clk);
      #1 chk("midop_pre", 64'(a_rdata), 64'(8'h5A));
      a_req = 1; a_we = 1; a_addr = 7; a_wdata = 8'h11;
      @(negedge clk);
      #1 chk("midop_write", 64'({mem_lr_n, mem_addr}), 64'({1'b0, 4'd7}));
      rst_n = 0;
      #1 chk("midop_reset", outs(), pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
      n_ack = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 n_ack += int'(a_ack) + int'(b_ack);
      end
      a_req = 0;
      rst_n = 1;
      chk("midop_no_ack", 64'(n_ack), 64'(0));
      txn(0, 1, 2, 8'h5A);
      txn(0, 0, 2, 8'h00);
      @(negedge clk);
      #1 chk("midop_post_rd2", 64'(a_rdata), 64'(8'h5A));
      txn(0, 0, 7, 8'h00);
      @(negedge clk);
      #1 chk("midop_readback", 64'(a_rdata), 64'(0));

      // randomized traffic against the model
      do_reset();
      m_cnt = 0; m_owner = 0; m_we = 0; m_prio = 0; m_addr = 0; m_wd = 0; m_ard = 0; m_brd = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      a_waits = 0; b_waits = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ena = ($urandom_range(0, 4) != 0);
         #1 chk($sformatf("rand%0d", c), outs(),
                pack(ena && m_cnt == 1 && !m_owner, ena && m_cnt == 1 && m_owner, m_cnt != 0,
                     !(m_cnt == 2 && m_we), !(m_cnt == 2 && !m_we), m_addr, m_wd, m_ard, m_brd));
         if (b_ack && a_req) a_waits++;
         if (a_ack && b_req) b_waits++;
         if (a_ack) chk("fair_a", 64'(a_waits <= 1), 64'(1));
         if (b_ack) chk("fair_b", 64'(b_waits <= 1), 64'(1));
         if (a_ack) begin
            if ($urandom_range(0, 1) == 1) new_a(); else a_req = 0;
         end else if (!a_req && $urandom_range(0, 2) == 0) new_a();
         if (b_ack) begin
            if ($urandom_range(0, 1) == 1) new_b(); else b_req = 0;
         end else if (!b_req && $urandom_range(0, 2) == 0) new_b();
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the 16-byte DFF RAM. It accepts independent read/write requests from port A and port B, serializes them onto the RAM's single address/data/strobe interface (active-low `lr_n` write, active-low `ce_n` read), and returns read data plus a one-cycle acknowledge to the winning port. It sits between the two on-chip masters and the RAM and is the only block that drives the RAM's control pins.

## Interface
- `ADDR_BITS`, default 4: RAM address width (16 locations).
- `DATA_BITS`, default 8: RAM word width.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; the arbiter freezes when low. The same `ena` drives the RAM.
- `a_req`, `b_req` in 1: request. Held high with its qualifiers until the acknowledge.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` in ADDR_BITS: target address.
- `a_wdata`, `b_wdata` in DATA_BITS: write data.
- `a_ack`, `b_ack` out 1: transaction complete; high for exactly one enabled cycle.
- `a_rdata`, `b_rdata` out DATA_BITS: read result. Registered and held until that port's next read completes.
- `mem_addr` out ADDR_BITS: RAM address.
- `mem_wdata` out DATA_BITS: RAM write data.
- `mem_lr_n` out 1: RAM write strobe, active-low.
- `mem_ce_n` out 1: RAM read strobe, active-low.
- `mem_rdata` in DATA_BITS: RAM registered read data.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: if any `req` is high, select a winner and latch owner, `we`, addr and wdata into `mem_addr`/`mem_wdata`. Go to WRITE if `we`=1, otherwise READ. With no request, stay in IDLE.
- WRITE: drive `mem_lr_n`=0 for one cycle. The RAM writes on the closing edge. Go to RESP.
- READ: drive `mem_ce_n`=0 for one cycle. The RAM registers data on the closing edge. Go to RESP.
- RESP: assert the owner's `ack`. On a read, capture `mem_rdata` into the owner's `rdata` on the closing edge. Update priority. Go to IDLE.
- Strobes are never both low. Outside WRITE/READ both are 1.
- Round-robin priority:
  - A priority pointer `prio` resets to A.
  - Both requesting: the `prio` port wins.
  - One requesting: that port wins.
  - After RESP, `prio` becomes the port that did not win.
  - No port waits more than one foreign transaction.
- Once latched in IDLE, a transaction is committed. Dropping `req` before `ack` does not cancel it. Changing `addr`/`wdata` after the latch has no effect.
- A requester must drop `req` in the cycle after `ack`, or re-arm it for a new transaction. A `req` still high in IDLE starts a new transaction.
- Same-address accesses from A and B are serialized in grant order. A read after a write returns the written value.
- `ena`=0: state, latched fields, `prio`, `rdata` and strobes hold. `ack` is gated low. Because the RAM is also frozen, the pending access executes on the next `ena`=1 edge.

## Timing
- Reset values: state IDLE, `prio`=A, `mem_lr_n`=1, `mem_ce_n`=1, `mem_addr`=0, `mem_wdata`=0, `a_rdata`=`b_rdata`=0, `a_ack`=`b_ack`=0, `busy`=0.
- `ack` is decoded from registered state (RESP and owner) and `ena`. All other outputs are registered.
- Latency with `ena` held high:
  - `req` sampled at edge E0, which leaves IDLE.
  - Strobe is low during cycle E0–E1.
  - `ack` is high during cycle E1–E2.
  - `rdata` is valid from E2 and is held.
- Throughput: one transaction per 3 cycles. Back-to-back alternating A/B requests with `req` held sustain A,B,A,B… at 3 cycles each.
- Reset asserted mid-transaction: everything returns to reset values immediately. The in-flight transaction is abandoned with no `ack`. The RAM is cleared by the same reset.
- `ena` dropped in any state: every low cycle extends that state by one cycle. No strobe or `ack` is lost or duplicated.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 with random inputs.
  - Response: all outputs at reset values; `mem_lr_n`=`mem_ce_n`=1; `busy`=0.
- Single port round trip:
  - Stimulus: A writes 0x3C to addr 5, then reads addr 5.
  - Response: `mem_lr_n` low for 1 cycle with `mem_addr`=5 and `mem_wdata`=0x3C. `a_ack` comes 2 cycles after the `req` sample. The read returns `a_rdata`=0x3C, held afterward.
- Contention:
  - Stimulus: A and B both read continuously, starting in the same cycle after reset.
  - Response: grant order A,B,A,B; each `ack` pulse 1 cycle wide; 3-cycle spacing.
- Collision:
  - Stimulus: B writes 0xA5 to addr 9 while A reads addr 9 simultaneously, with `prio`=B.
  - Response: the B write completes first; `a_rdata`=0xA5.
- Enable stall:
  - Stimulus: drop `ena` for 4 cycles during READ.
  - Response: `mem_ce_n` stays low through the stall; `a_ack` fires once, one enabled cycle later; data is correct.
- Reset mid-op:
  - Stimulus: assert `rst_n`=0 during WRITE.
  - Response: immediate return to reset values; no `ack`; a subsequent read of that address returns 0.
